// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver.
// Mid-bit sampling, framing error detection, break hold-off.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 2501
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [11:0] BIT_END  = 12'(CLKS_PER_BIT - 1);
  localparam logic [11:0] HALF_END = 12'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t      state;
  logic        rx_m;
  logic        rx_s;
  logic [11:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;

  // two-flop synchronizer for the asynchronous line, idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // frame FSM with registered data/valid/frame_err/busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        STOP: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (rx_s) begin
              data  <= shreg;
              valid <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized frames against a queue model.
// Second instance covers the default bit period.
module tb_uart_receiver;

  localparam int CPB  = 16;
  localparam int CPB2 = 2501;
  localparam int LAT  = 2 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  logic       rx2;
  logic [7:0] data2;
  logic       valid2;
  logic       frame_err2;
  logic       busy2;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  int n_valid  = 0;
  int n_ferr   = 0;
  int n_valid2 = 0;
  int n_ferr2  = 0;
  int n_exp_valid = 0;
  int n_exp_ferr  = 0;

  logic [7:0] exp_q[$];
  int         st_q[$];
  int         vt_q[$];
  logic [7:0] model_last = 8'h00;
  logic       prev_v = 1'b0;

  uart_receiver #(.CLKS_PER_BIT(CPB)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  uart_receiver u_slow (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx2),
    .data      (data2),
    .valid     (valid2),
    .frame_err (frame_err2),
    .busy      (busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // monitor: pop expected bytes and latencies on each valid
  always @(negedge clk) begin
    if (prev_v) chk("valid_pulse", {31'd0, valid}, 32'd0);
    prev_v = valid;
    if (valid || frame_err)
      chk("excl", {31'd0, valid & frame_err}, 32'd0);
    if (frame_err) n_ferr++;
    if (valid) begin
      n_valid++;
      vt_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexp_valid", 32'd1, 32'd0);
      end else begin
        chk("data", {24'd0, data}, {24'd0, exp_q.pop_front()});
        chk("latency",
            {31'd0, (cyc - st_q[0] >= LAT - 1) &&
                    (cyc - st_q[0] <= LAT + 1)}, 32'd1);
        void'(st_q.pop_front());
      end
    end
    if (valid2) n_valid2++;
    if (frame_err2) n_ferr2++;
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic ok);
    if (ok) begin
      exp_q.push_back(b);
      st_q.push_back(cyc);
      model_last = b;
      n_exp_valid++;
    end else begin
      n_exp_ferr++;
    end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(ok);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int target);
    int t;
    t = 0;
    while (n_valid < target && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (n_valid < target) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int v0;
    int f0;
    int bc;
    rst_n = 1'b0;
    rx    = 1'b1;
    rx2   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle(5);

    send_frame(8'hA5, 1'b1);
    idle(3);
    chk("a5_count", n_valid, 32'd1);
    chk("a5_ferr", n_ferr, 32'd0);
    chk("a5_busy", {31'd0, busy}, 32'd0);
    chk("a5_data", {24'd0, data}, 32'h A5);

    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    wait_valid(3);
    idle(3);
    chk("b2b_count", n_valid, 32'd3);
    chk("b2b_gap", vt_q[2] - vt_q[1], 32'd160);
    chk("b2b_data", {24'd0, data}, 32'h C3);

    f0 = n_ferr;
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    chk("fe_count", n_ferr - f0, 32'd1);
    chk("fe_busy_hold", {31'd0, busy}, 32'd1);
    chk("fe_data_keep", {24'd0, data}, {24'd0, model_last});
    rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("fe_idle", {31'd0, busy}, 32'd0);

    v0 = n_valid;
    f0 = n_ferr;
    bc = 0;
    rx = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 5) rx = 1'b1;
      @(negedge clk);
      if (busy) bc++;
    end
    chk("gl_busy_max", {31'd0, bc <= 10}, 32'd1);
    chk("gl_busy_seen", {31'd0, bc > 0}, 32'd1);
    chk("gl_novalid", n_valid - v0, 32'd0);
    chk("gl_noferr", n_ferr - f0, 32'd0);
    chk("gl_idle", {31'd0, busy}, 32'd0);

    v0 = n_valid;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("mr_data", {24'd0, data}, 32'd0);
    chk("mr_valid", {31'd0, valid}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_ferr", {31'd0, frame_err}, 32'd0);
    model_last = 8'h00;
    rst_n = 1'b1;
    repeat (CPB / 2 - 4) @(negedge clk);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    idle(CPB);
    chk("mr_lost", n_valid - v0, 32'd0);
    send_frame(8'h81, 1'b1);
    idle(3);
    chk("mr_81", n_valid - v0, 32'd1);
    chk("mr_81_data", {24'd0, data}, 32'h 81);

    for (int k = 0; k < 24; k++) begin
      logic [7:0] b;
      logic       ok;
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(b, ok);
      chk("rnd_data", {24'd0, data}, {24'd0, model_last});
      idle(ok ? $urandom_range(0, 20) : $urandom_range(3, 20));
    end
    idle(20);
    chk("end_q", exp_q.size(), 32'd0);
    chk("end_valid", n_valid, n_exp_valid);
    chk("end_ferr", n_ferr, n_exp_ferr);

    rx2 = 1'b0;
    repeat (CPB2 * 9) @(negedge clk);
    rx2 = 1'b1;
    repeat (CPB2 + 100) @(negedge clk);
    chk("slow_count", n_valid2, 32'd1);
    chk("slow_data", {24'd0, data2}, 32'd0);
    chk("slow_ferr", n_ferr2, 32'd0);
    chk("slow_busy", {31'd0, busy2}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
